// File: rtl/cla_nibble_serial_adder_if.sv
// Operand/result bundle for the nibble-serial adder: valid/ready operand channel in, valid/ready result channel out.
// Optional macro SUBTRACT_EN adds the sub select that travels with the operands.
interface cla_nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SUBTRACT_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // master = operand source / result consumer, slave = the adder
    modport master (
        output in_valid, a, b, cin,
`ifdef SUBTRACT_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin,
`ifdef SUBTRACT_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/cla_nibble_serial_adder.sv
// Purpose: WIDTH-bit adder that pushes one nibble per cycle (LSB first) through one 4-bit CLA; optional SUBTRACT_EN adds a - b.
// Latency: accept at edge k -> out_valid after edge k+NIBBLES; no bypass, so back-to-back period is NIBBLES+2 cycles.
// Backpressure: result and out_valid are held in DONE until out_ready; in_ready is low from accept until the cycle after the output handshake.

module cla_nibble_serial_adder_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Flat lookahead: every carry is a two-level function of g/p/ci, no ripple.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ c;
endmodule

module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cla_nibble_serial_adder_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic [3:0]       nib_s;
    logic             nib_co;

`ifdef SUBTRACT_EN
    // a - b = a + ~b + 1; cout then reads as NOT borrow.
    always_comb begin
        b_load     = bus.b;
        carry_load = bus.cin;
        if (bus.sub) begin
            b_load     = ~bus.b;
            carry_load = 1'b1;
        end
    end
`else
    always_comb begin
        b_load     = bus.b;
        carry_load = bus.cin;
    end
`endif

    cla_nibble_serial_adder_cla4 u_cla (
        .a  (a_sh[3:0]),
        .b  (b_sh[3:0]),
        .ci (carry),
        .s  (nib_s),
        .co (nib_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            a_sh        <= '0;
            b_sh        <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh       <= bus.a;
                        b_sh       <= b_load;
                        carry      <= carry_load;
                        idx        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    // Nibble sums enter from the top so nibble 0 lands at [3:0] after the last pass.
                    sum_r <= {nib_s, sum_r[WIDTH-1:4]};
                    carry <= nib_co;
                    if (idx == LAST_IDX) begin
                        cout_r      <= nib_co;
                        idx         <= '0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    idx         <= '0;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Directed bench for the nibble-serial adder: 16-bit instance for the main vectors, 32-bit instance for the wide carry case.
module tb_cla_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cla_nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
    cla_nibble_serial_adder_if #(.WIDTH(32)) bus32 ();

    cla_nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    cla_nibble_serial_adder #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start16(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic [15:0] exp_sum, input logic exp_cout);
        int n;
        n = 0;
        while (!bus16.in_ready && n < 20) begin
            tick();
            n++;
        end
        bus16.a        = a;
        bus16.b        = b;
        bus16.cin      = cin;
        bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        check({tag, "_busy"}, bus16.in_ready, 0);
        n = 0;
        while (!bus16.out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_sum"}, bus16.sum, exp_sum);
        check({tag, "_cout"}, bus16.cout, exp_cout);
    endtask

    task automatic finish16(input string tag);
        bus16.out_ready = 1'b1;
        tick();
        bus16.out_ready = 1'b0;
        check({tag, "_in_ready_after"}, bus16.in_ready, 1);
        check({tag, "_out_valid_after"}, bus16.out_valid, 0);
    endtask

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] exp_sum, input logic exp_cout);
        start16(tag, a, b, cin, exp_sum, exp_cout);
        finish16(tag);
    endtask

    initial begin
        int n;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b0;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.out_ready = 1'b0;
`ifdef SUBTRACT_EN
        bus16.sub = 1'b0;
        bus32.sub = 1'b0;
`endif
        #12;
        check("rst_in_ready", bus16.in_ready, 1);
        check("rst_out_valid", bus16.out_valid, 0);
        check("rst_sum", bus16.sum, 0);
        check("rst_cout", bus16.cout, 0);
        check("rst32_in_ready", bus32.in_ready, 1);
        check("rst32_out_valid", bus32.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Result held under backpressure while a competing operand is offered.
        start16("bp", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        bus16.a        = 16'hAAAA;
        bus16.b        = 16'hAAAA;
        bus16.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", bus16.out_valid, 1);
            check("bp_hold_sum", bus16.sum, 16'h5555);
            check("bp_hold_cout", bus16.cout, 0);
            check("bp_hold_in_ready", bus16.in_ready, 0);
        end
        bus16.in_valid = 1'b0;
        finish16("bp");
        run16("after_bp", 16'h0101, 16'h0202, 1'b0, 16'h0303, 1'b0);

        run16("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run16("all_ones_cin", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        run16("zero_cin", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);

        // Reset pulsed with idx==2: partial sum already non-zero in the top nibbles.
        bus16.a        = 16'h1234;
        bus16.b        = 16'h4321;
        bus16.cin      = 1'b0;
        bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus16.out_valid, 0);
        check("mid_rst_sum", bus16.sum, 0);
        check("mid_rst_cout", bus16.cout, 0);
        check("mid_rst_in_ready", bus16.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("mid_rst_no_result", bus16.out_valid, 0);
        run16("after_rst", 16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0);

        // 32-bit instance: carry rippled through eight nibbles.
        bus32.a        = 32'hFFFF_FFFF;
        bus32.b        = 32'h0000_0001;
        bus32.cin      = 1'b0;
        bus32.in_valid = 1'b1;
        tick();
        bus32.in_valid = 1'b0;
        n = 0;
        while (!bus32.out_valid && n < 40) begin
            tick();
            n++;
        end
        check("w32_latency", n, 8);
        check("w32_sum", bus32.sum, 32'h0000_0000);
        check("w32_cout", bus32.cout, 1);
        bus32.out_ready = 1'b1;
        tick();
        bus32.out_ready = 1'b0;
        check("w32_in_ready_after", bus32.in_ready, 1);

`ifdef SUBTRACT_EN
        bus16.sub = 1'b1;
        run16("sub_borrow", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
        run16("sub_no_borrow", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
        run16("sub_cin_ignored", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1);
        bus16.sub = 1'b0;
        run16("sub_off_add", 16'h0007, 16'h0005, 1'b1, 16'h000D, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
